// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one valid/ready pipeline stage for a WIDTH-bit payload.
//
// Optional feature: define PIPE_STAGE_REG_SKID_EN to add a skid register.
//   - Defined:   two entries (main + skid). ready_o is a register output
//                (NOT skid full), so there is no ready_i -> ready_o path.
//   - Undefined: a single main register. ready_o = !valid_o | ready_i,
//                which is combinational from ready_i.
//
// Ports
//   clk_i        in   1      clock, all state updates on the rising edge
//   rst_i        in   1      synchronous reset, active low
//   flush_i      in   1      drops every held entry (next cycle is a bubble)
//   valid_i      in   1      upstream payload valid
//   ready_o      out  1      stage accepts a payload this cycle
//   data_i       in   WIDTH  upstream payload
//   valid_o      out  1      downstream payload valid
//   ready_i      in   1      downstream accepts the payload this cycle
//   data_o       out  WIDTH  downstream payload (main register)
//   occupancy_o  out  2      number of held entries
//
// Parameters
//   WIDTH    payload width, 1..256
//   RST_VAL  data_o value after reset or flush

module pipe_stage_reg #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       occupancy_o
);

    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = main_valid & ready_i;

    assign valid_o = main_valid;
    assign data_o  = main_data;

`ifdef PIPE_STAGE_REG_SKID_EN

    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // The skid entry is only ever filled behind a full main entry, so a
    // free skid slot is exactly the condition for taking one more payload.
    assign ready_o = ~skid_valid;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            main_valid <= 1'b0;
            main_data  <= RST_VAL;
            skid_valid <= 1'b0;
            skid_data  <= RST_VAL;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            main_data  <= RST_VAL;
            skid_valid <= 1'b0;
            skid_data  <= RST_VAL;
        end else if (out_xfer) begin
            if (skid_valid) begin
                // ready_o is low here, so no new payload can arrive this edge
                main_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_data <= data_i;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            if (main_valid) begin
                skid_data  <= data_i;
                skid_valid <= 1'b1;
            end else begin
                main_data  <= data_i;
                main_valid <= 1'b1;
            end
        end
    end

    assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

`else

    assign ready_o = ~main_valid | ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            main_valid <= 1'b0;
            main_data  <= RST_VAL;
        end else if (flush_i) begin
            main_valid <= 1'b0;
            main_data  <= RST_VAL;
        end else if (in_xfer) begin
            // covers both the empty case and the simultaneous in/out case
            main_data  <= data_i;
            main_valid <= 1'b1;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
        end
    end

    assign occupancy_o = {1'b0, main_valid};

`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (1..256).
REQ-002 Parameter RST_VAL, default all-zero, value of data_o after reset or flush.
REQ-003 Port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst_i  input  1  reset, synchronous, active-low.
REQ-005 Port flush_i  input  1  kills every held entry; inserts a bubble.
REQ-006 Port valid_i  input  1  upstream payload valid.
REQ-007 Port ready_o  output  1  stage can accept a payload this cycle.
REQ-008 Port data_i  input  WIDTH  upstream payload.
REQ-009 Port valid_o  output  1  downstream payload valid.
REQ-010 Port ready_i  input  1  downstream accepts the payload this cycle.
REQ-011 Port data_o  output  WIDTH  downstream payload.
REQ-012 Port occupancy_o  output  2  number of held entries (0..2).

Function
REQ-013 An input transfer SHALL occur when valid_i and ready_o are both high on a rising edge.
REQ-014 An output transfer SHALL occur when valid_o and ready_i are both high on a rising edge.
REQ-015 An accepted payload SHALL appear on data_o with valid_o high exactly 1 cycle after acceptance when the stage was empty.
REQ-016 Payload order SHALL be preserved; no payload SHALL be duplicated or dropped except by flush_i.
REQ-017 While valid_o is high and ready_i is low, data_o and valid_o SHALL hold stable.
REQ-018 With ready_i held high and valid_i held high, throughput SHALL be 1 payload per cycle.
REQ-019 Storage is a main register (drives data_o) plus, when the Configuration feature is enabled, one skid register.
REQ-020 Simultaneous input and output transfers with one entry held SHALL load the new payload into the main register; occupancy stays 1.
REQ-021 An input transfer with the main register full and no output transfer SHALL load the skid register; occupancy becomes 2.
REQ-022 An output transfer with the skid register full SHALL move the skid payload to the main register in the same edge.
REQ-023 flush_i high on an edge SHALL set valid_o=0, occupancy_o=0, data_o=RST_VAL on the next cycle; any simultaneous input transfer is discarded.
REQ-024 flush_i SHALL take priority over every other event except reset.
REQ-025 occupancy_o SHALL always equal the count of valid held entries.

Reset
REQ-026 While rst_i is low on a rising edge, all state SHALL clear: valid_o=0, data_o=RST_VAL, occupancy_o=0; valid_i, data_i and flush_i are ignored.
REQ-027 ready_o SHALL be high in the first cycle after rst_i returns high.
REQ-028 Reset asserted mid-transfer SHALL discard all held payloads, with no partial output.

Configuration
REQ-029 Macro PIPE_STAGE_REG_SKID_EN defined: skid register present; ready_o is registered, equal to NOT(skid full), with no combinational path from ready_i to ready_o; occupancy_o reaches 2.
REQ-030 Macro PIPE_STAGE_REG_SKID_EN undefined: single entry; ready_o = NOT valid_o OR ready_i (combinational); occupancy_o never exceeds 1; REQ-021/022 do not apply.

Verification
REQ-031 Reset, then valid_i=1 with data_i=0x0000_00A5 for one cycle and ready_i=1 -> next cycle valid_o=1, data_o=0x0000_00A5; following cycle valid_o=0.
REQ-032 Stream 0x1,0x2,0x3,0x4 back-to-back with ready_i=1 -> data_o shows 0x1..0x4 on 4 consecutive cycles starting 1 cycle after the first accept.
REQ-033 SKID_EN: accept 0x10, drop ready_i, offer 0x20 -> occupancy_o=2, ready_o=0, data_o holds 0x10; raise ready_i -> 0x10 then 0x20 delivered, ready_o=1.
REQ-034 Two entries held (SKID_EN) and flush_i=1 together with valid_i=1, data_i=0x99 -> next cycle valid_o=0, occupancy_o=0, data_o=RST_VAL; 0x99 never appears.
REQ-035 rst_i=0 for one edge while data_o=0xDEAD_BEEF is stalled -> next cycle valid_o=0, data_o=RST_VAL, ready_o=1.
REQ-036 Without SKID_EN: valid_o=1, ready_i=0 -> ready_o=0 in the same cycle; set ready_i=1 -> ready_o=1 in the same cycle.
